// File: rtl/mem_pkg.sv
// Shared types and defaults for the M-stage data memory access unit.
package mem_pkg;

  // Access size as encoded on MemSizeM; the reserved code behaves as a word.
  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeRsvd = 2'b11
  } memSize_e;

  // Bus transaction sequencer states.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StDone   = 2'b10
  } memState_e;

  // Default number of ACCESS cycles to wait for dm_ack before flagging a bus error.
  localparam int unsigned TimeoutCyclesDefault = 255;

  // Natural alignment: halves on even addresses, words on multiples of four.
  function automatic logic isAligned(memSize_e size, logic [1:0] offset);
    logic ok;
    unique case (size)
      SizeByte: ok = 1'b1;
      SizeHalf: ok = ~offset[0];
      default:  ok = (offset == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store replication, byte enables, load extract/extend.
module mem_lane_align
  import mem_pkg::*;
(
  input  memSize_e    size,
  input  logic [1:0]  offset,
  input  logic        isSigned,
  input  logic [31:0] storeData,
  input  logic [31:0] loadWord,
  output logic [31:0] laneData,
  output logic [3:0]  byteEn,
  output logic [31:0] loadData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel = loadWord[{offset, 3'b000} +: 8];
  assign halfSel = offset[1] ? loadWord[31:16] : loadWord[15:0];

  // Decode size into lane placement for stores and extraction for loads.
  always_comb begin
    laneData = storeData;
    byteEn   = 4'b1111;
    loadData = loadWord;
    unique case (size)
      SizeByte: begin
        laneData = {4{storeData[7:0]}};
        byteEn   = 4'b0001 << offset;
        loadData = {{24{isSigned & byteSel[7]}}, byteSel};
      end
      SizeHalf: begin
        laneData = {2{storeData[15:0]}};
        byteEn   = offset[1] ? 4'b1100 : 4'b0011;
        loadData = {{16{isSigned & halfSel[15]}}, halfSel};
      end
      default: begin
        laneData = storeData;
        byteEn   = 4'b1111;
        loadData = loadWord;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// M-stage data memory access: stalls the pipeline around a single registered bus
// request, with alignment checking, lane steering and an ack timeout.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack
);

  // Counter holds 0..TIMEOUT_CYCLES-1 ACCESS cycles already spent without ack.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  memState_e      stateQ, stateD;
  memSize_e       sizeIn, sizeQ, alignSize;
  logic [1:0]     offQ, alignOff;
  logic           signedQ, isReadQ, busErrQ;
  logic [CntW-1:0] cntQ;
  logic [31:0]    dataQ;

  logic           accessReq, alignedIn, startAcc, timeoutHit;
  logic [31:0]    laneData, loadData;
  logic [3:0]     byteEn;

  assign sizeIn     = memSize_e'(MemSizeM);
  assign accessReq  = MemReadM | MemWriteM;
  assign alignedIn  = isAligned(sizeIn, ALUOutM[1:0]);
  assign startAcc   = (stateQ == StIdle) && accessReq && alignedIn;
  assign timeoutHit = (stateQ == StAccess) && !dm_ack && (cntQ == CntLast);

  // In IDLE the steering works on the incoming access; afterwards on the latched one.
  assign alignSize = (stateQ == StIdle) ? sizeIn : sizeQ;
  assign alignOff  = (stateQ == StIdle) ? ALUOutM[1:0] : offQ;

  mem_lane_align u_lane_align (
    .size      (alignSize),
    .offset    (alignOff),
    .isSigned  (signedQ),
    .storeData (WriteDataM),
    .loadWord  (dm_rdata),
    .laneData  (laneData),
    .byteEn    (byteEn),
    .loadData  (loadData)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state: an ack wins over a simultaneous timeout since both lead to DONE.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:   if (startAcc) stateD = StAccess;
      StAccess: if (dm_ack || timeoutHit) stateD = StDone;
      StDone:   stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  // Pipeline-facing outputs.
  always_comb begin
    StallM    = startAcc || (stateQ == StAccess);
    MisalignM = (stateQ == StIdle) && accessReq && !alignedIn;
    BusErrM   = (stateQ == StDone) && busErrQ;
    ReadDataM = (stateQ == StDone) ? dataQ : 32'h0;
  end

  // Bus request, latched access attributes, wait counter and captured load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= 32'h0;
      dm_wdata <= 32'h0;
      dm_be    <= 4'h0;
      sizeQ    <= SizeByte;
      offQ     <= 2'b00;
      signedQ  <= 1'b0;
      isReadQ  <= 1'b0;
      busErrQ  <= 1'b0;
      cntQ     <= '0;
      dataQ    <= 32'h0;
    end else if (startAcc) begin
      dm_req   <= 1'b1;
      dm_we    <= !MemReadM;  // a load wins when both strobes are set
      dm_addr  <= {ALUOutM[31:2], 2'b00};
      dm_wdata <= laneData;
      dm_be    <= byteEn;
      sizeQ    <= sizeIn;
      offQ     <= ALUOutM[1:0];
      signedQ  <= MemSignedM;
      isReadQ  <= MemReadM;
      busErrQ  <= 1'b0;
      cntQ     <= '0;
      dataQ    <= 32'h0;
    end else if (stateQ == StAccess) begin
      if (dm_ack) begin
        dm_req <= 1'b0;
        dm_we  <= 1'b0;
        dataQ  <= isReadQ ? loadData : 32'h0;
      end else if (timeoutHit) begin
        dm_req  <= 1'b0;
        dm_we   <= 1'b0;
        busErrQ <= 1'b1;
        dataQ   <= 32'h0;
      end else begin
        cntQ <= cntQ + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access with directed corner cases.
module tb_mem_access;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReadM, MemWriteM, MemSignedM;
  logic [1:0]  MemSizeM;
  logic [31:0] ALUOutM, WriteDataM, dm_rdata;
  logic        dm_ack;
  logic [31:0] ReadDataM, dm_addr, dm_wdata;
  logic        StallM, MisalignM, BusErrM, dm_req, dm_we;
  logic [3:0]  dm_be;

  // Second instance with a short timeout, sharing all inputs.
  logic [31:0] t4ReadData, t4Addr, t4Wdata;
  logic        t4Stall, t4Mis, t4BusErr, t4Req, t4We;
  logic [3:0]  t4Be;

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .MemSizeM(MemSizeM), .MemSignedM(MemSignedM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
    .MisalignM(MisalignM), .BusErrM(BusErrM), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_rdata(dm_rdata),
    .dm_ack(dm_ack)
  );

  mem_access #(.TIMEOUT_CYCLES(4)) dutT4 (
    .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .MemSizeM(MemSizeM), .MemSignedM(MemSignedM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .ReadDataM(t4ReadData), .StallM(t4Stall),
    .MisalignM(t4Mis), .BusErrM(t4BusErr), .dm_req(t4Req), .dm_we(t4We),
    .dm_addr(t4Addr), .dm_wdata(t4Wdata), .dm_be(t4Be), .dm_rdata(dm_rdata),
    .dm_ack(dm_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } reqT;

  typedef struct {
    logic        mis;
    logic [31:0] data;
    logic        busErr;
    int          reqCycles;
  } rspT;

  reqT reqQ[$];
  rspT rspQ[$];
  int  nTests = 0;
  int  nFail  = 0;
  logic monEn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sizeBytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] expLoad(input int nb, input int off, input logic sgn,
                                          input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * off);
    if (nb == 1) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else if (nb == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] expBe(input int nb, input int off);
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] expWdata(input int nb, input logic [31:0] wd);
    if (nb == 1) return (wd & 32'hFF) * 32'h01010101;
    if (nb == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  // ---------------- monitor ----------------
  logic reqPrev, stallPrev, doneNow;
  int   reqRun, stallRun;
  reqT  rExp;
  rspT  sExp;

  always @(negedge clk) begin
    if (!rst_n || !monEn) begin
      reqPrev = 1'b0; stallPrev = 1'b0; reqRun = 0; stallRun = 0;
    end else begin
      if (dm_req && !reqPrev) begin
        if (reqQ.size() == 0) check("unexpected_req", 32'd1, 32'd0);
        else begin
          rExp = reqQ.pop_front();
          check("req_addr", dm_addr, rExp.addr);
          check("req_we", 32'(dm_we), 32'(rExp.we));
          if (rExp.we) check("req_wdata", dm_wdata, rExp.wdata);
          check("req_be", 32'(dm_be), 32'(rExp.be));
        end
      end
      if (dm_req) reqRun++;
      if (StallM) stallRun++;
      doneNow = stallPrev && !StallM;
      if (MisalignM || doneNow) begin
        if (rspQ.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
        else begin
          sExp = rspQ.pop_front();
          check("rsp_misalign", 32'(MisalignM), 32'(sExp.mis));
          check("rsp_rdata", ReadDataM, sExp.data);
          check("rsp_buserr", 32'(BusErrM), 32'(sExp.busErr));
          if (MisalignM) begin
            check("mis_nostall", 32'(StallM), 32'd0);
            check("mis_noreq", 32'(dm_req), 32'd0);
          end else begin
            check("req_cycles", 32'(reqRun), 32'(sExp.reqCycles));
            check("stall_cycles", 32'(stallRun), 32'(sExp.reqCycles + 1));
          end
        end
        reqRun = 0; stallRun = 0;
      end else if (BusErrM) begin
        check("stray_buserr", 32'd1, 32'd0);
      end
      reqPrev = dm_req; stallPrev = StallM;
    end
  end

  // Watches the short-timeout instance during the timeout test.
  logic t4Watch = 1'b0;
  int   t4Stage, t4ReqCnt;
  logic [31:0] t4ErrData;
  logic t4ErrNext;

  always @(negedge clk) begin
    if (t4Watch) begin
      if (t4Stage == 0) begin
        if (t4Req) t4ReqCnt++;
        if (t4BusErr) begin t4Stage = 1; t4ErrData = t4ReadData; end
      end else if (t4Stage == 1) begin
        t4ErrNext = t4BusErr; t4Stage = 2;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic clearInputs();
    MemReadM = 0; MemWriteM = 0; MemSizeM = 0; MemSignedM = 0;
    ALUOutM = 0; WriteDataM = 0; dm_ack = 0;
  endtask

  task automatic idleCycle(input logic spurious);
    @(posedge clk); #1;
    clearInputs();
    ALUOutM = $urandom; dm_ack = spurious; dm_rdata = $urandom;
    #2;
    check("idle_stall", 32'(StallM), 32'd0);
    check("idle_req", 32'(dm_req), 32'd0);
    check("idle_rdata", ReadDataM, 32'd0);
  endtask

  // ackDelay: ACCESS cycle (1-based) carrying dm_ack; 0 means never.
  task automatic doAccess(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd, input logic sgn,
                          input logic [31:0] rdata, input int ackDelay);
    int nb, off;
    reqT r;
    rspT s;
    nb  = sizeBytes(sz);
    off = int'(addr % 4);
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; MemSizeM = sz; ALUOutM = addr;
    WriteDataM = wd; MemSignedM = sgn; dm_ack = 0; dm_rdata = $urandom;
    if ((off % nb) != 0) begin
      s.mis = 1; s.data = 0; s.busErr = 0; s.reqCycles = 0;
      rspQ.push_back(s);
      @(posedge clk); #1;
      clearInputs();
      return;
    end
    r.addr = addr & ~32'h3; r.we = !rd; r.be = expBe(nb, off); r.wdata = expWdata(nb, wd);
    reqQ.push_back(r);
    s.mis = 0;
    if (ackDelay == 0) begin
      s.data = 0; s.busErr = 1; s.reqCycles = TO;
    end else begin
      s.data = rd ? expLoad(nb, off, sgn, rdata) : 32'h0;
      s.busErr = 0; s.reqCycles = ackDelay;
    end
    rspQ.push_back(s);
    @(posedge clk); #1;
    for (int k = 1; k <= int'(TO); k++) begin
      if (k == ackDelay) begin
        dm_ack = 1; dm_rdata = rdata;
      end else begin
        dm_rdata = $urandom;
      end
      @(posedge clk); #1;
      dm_ack = 0;
      if (k == ackDelay) break;
    end
    clearInputs();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic rd, wr, sgn, spur;
    logic [1:0] sz;
    logic [31:0] addr;
    int sel, dly;

    rst_n = 0; clearInputs(); dm_rdata = 0;
    #3;
    check("rst_req", 32'(dm_req), 32'd0);
    check("rst_we", 32'(dm_we), 32'd0);
    check("rst_be", 32'(dm_be), 32'd0);
    check("rst_addr", dm_addr, 32'd0);
    check("rst_wdata", dm_wdata, 32'd0);
    check("rst_rdata", ReadDataM, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #2;
    check("post_rst_stall", 32'(StallM), 32'd0);
    check("post_rst_mis", 32'(MisalignM), 32'd0);
    check("post_rst_buserr", 32'(BusErrM), 32'd0);
    monEn = 1;

    // Timeout: both instances wait for an ack that never comes.
    t4Stage = 0; t4ReqCnt = 0; t4ErrData = 32'hFFFFFFFF; t4ErrNext = 1'b1;
    t4Watch = 1;
    doAccess(1, 0, 2'd2, 32'h0000_0400, 32'h0, 0, 32'h0, 0);
    repeat (3) idleCycle(0);
    t4Watch = 0;
    check("t4_stage", 32'(t4Stage), 32'd2);
    check("t4_req_cycles", 32'(t4ReqCnt), 32'd4);
    check("t4_buserr_rdata", t4ErrData, 32'd0);
    check("t4_buserr_one_cycle", 32'(t4ErrNext), 32'd0);

    // Directed cases.
    doAccess(1, 0, 2'd2, 32'h0000_0100, 32'h0, 0, 32'hDEADBEEF, 1);
    doAccess(1, 0, 2'd0, 32'h0000_0103, 32'h0, 1, 32'h80112233, 1);
    doAccess(1, 0, 2'd0, 32'h0000_0103, 32'h0, 0, 32'h80112233, 2);
    doAccess(0, 1, 2'd1, 32'h0000_0202, 32'h0000ABCD, 0, 32'h0, 5);
    doAccess(1, 0, 2'd2, 32'h0000_0101, 32'h0, 0, 32'h0, 1);
    doAccess(1, 0, 2'd1, 32'h0000_0006, 32'h0, 1, 32'h9ABC_0000, TO);
    doAccess(1, 1, 2'd3, 32'h0000_0010, 32'h5555_AAAA, 0, 32'h0BAD_F00D, 3);
    idleCycle(1);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 8);
      rd  = (sel <= 3) || (sel == 7);
      wr  = (sel >= 4 && sel <= 7);
      sz  = 2'($urandom_range(0, 3));
      sgn = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(sizeBytes(sz) - 1);
      dly = $urandom_range(0, TO);
      if (!rd && !wr) begin
        spur = 1'($urandom_range(0, 1));
        idleCycle(spur);
      end else begin
        doAccess(rd, wr, sz, addr, $urandom, sgn, $urandom, dly);
      end
      if ($urandom_range(0, 2) == 0) idleCycle(1'($urandom_range(0, 1)));
    end
    idleCycle(0);

    // Reset in ACCESS, then a late ack that must be ignored.
    monEn = 0;
    @(posedge clk); #1;
    MemReadM = 1; MemSizeM = 2'd2; ALUOutM = 32'h0000_0300; dm_ack = 0;
    @(posedge clk); #1;
    check("rst_acc_req_before", 32'(dm_req), 32'd1);
    clearInputs();
    #2 rst_n = 0;
    #1;
    check("rst_acc_req", 32'(dm_req), 32'd0);
    check("rst_acc_be", 32'(dm_be), 32'd0);
    check("rst_acc_addr", dm_addr, 32'd0);
    check("rst_acc_stall", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    rst_n = 1; dm_ack = 1; dm_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dm_ack = 0;
    check("late_ack_req", 32'(dm_req), 32'd0);
    check("late_ack_stall", 32'(StallM), 32'd0);
    check("late_ack_rdata", ReadDataM, 32'd0);
    @(posedge clk); #1;
    check("late_ack_rdata2", ReadDataM, 32'd0);
    check("late_ack_buserr", 32'(BusErrM), 32'd0);
    monEn = 1;
    doAccess(1, 0, 2'd2, 32'h0000_0300, 32'h0, 0, 32'hCAFE_0001, 2);
    idleCycle(0);

    check("req_queue_drained", 32'(reqQ.size()), 32'd0);
    check("rsp_queue_drained", 32'(rspQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles to wait for dm_ack before a bus error.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port MemReadM  input  1  load in M stage.
REQ-005 SHALL have port MemWriteM  input  1  store in M stage.
REQ-006 SHALL have port MemSizeM  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-007 SHALL have port MemSignedM  input  1  sign-extend loads when 1.
REQ-008 SHALL have port ALUOutM  input  32  byte address.
REQ-009 SHALL have port WriteDataM  input  32  store data, right-aligned.
REQ-010 SHALL have port ReadDataM  output  32  aligned and extended load data to MEM/WB.
REQ-011 SHALL have port StallM  output  1  freeze F/D/E/M and bubble MEM/WB while high.
REQ-012 SHALL have port MisalignM  output  1  address-error pulse.
REQ-013 SHALL have port BusErrM  output  1  timeout pulse.
REQ-014 SHALL have port dm_req  output  1  memory request, registered.
REQ-015 SHALL have port dm_we  output  1  write strobe, registered.
REQ-016 SHALL have port dm_addr  output  32  word address: {ALUOutM[31:2],2'b00}.
REQ-017 SHALL have port dm_wdata  output  32  lane-placed store data.
REQ-018 SHALL have port dm_be  output  4  byte enables.
REQ-019 SHALL have port dm_rdata  input  32  read data, valid with dm_ack.
REQ-020 SHALL have port dm_ack  input  1  one-cycle completion.

Function
REQ-021 SHALL implement the FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-022 In IDLE, an aligned MemReadM|MemWriteM (cycle T) SHALL make StallM=1 combinationally in T, latch addr/data/size/be, and enter ACCESS; MemReadM has priority if both are set.
REQ-023 In ACCESS, dm_req SHALL be held at 1 with stable dm_addr, dm_we, dm_wdata and dm_be until the edge sampling dm_ack=1, and StallM SHALL stay 1.
REQ-024 On the ack edge, load data SHALL be captured, dm_req SHALL drop, and the FSM SHALL enter DONE.
REQ-025 In DONE, StallM SHALL be 0 and ReadDataM SHALL hold the captured value; the FSM SHALL return to IDLE on the next edge without reissuing the request.
REQ-026 Minimum latency SHALL be 2 stall cycles (ack in the first ACCESS cycle), with DONE at T+2.
REQ-027 Alignment: half requires addr[0]=0 and word requires addr[1:0]=00; otherwise there SHALL be no request, MisalignM=1 for that cycle, StallM=0 and ReadDataM=0.
REQ-028 Little-endian byte lanes: sb SHALL use be=0001<<addr[1:0] with the byte replicated on all lanes; sh SHALL use be=0011 or 1100 with the half replicated; sw SHALL use be=1111.
REQ-029 Loads SHALL select the lane by addr[1:0] and zero- or sign-extend it per MemSignedM.
REQ-030 A wait counter SHALL count ACCESS cycles; on reaching TIMEOUT_CYCLES without ack, dm_req SHALL drop and the FSM SHALL enter DONE with BusErrM=1 for that DONE cycle and ReadDataM=0.
REQ-031 dm_ack outside ACCESS SHALL be ignored.
REQ-032 An ack and timeout on the same edge SHALL be resolved as ack.
REQ-033 With neither MemReadM nor MemWriteM set, StallM SHALL be 0, dm_req SHALL be 0, and ReadDataM SHALL be 0.

Reset
REQ-034 rst_n=0 SHALL force state=IDLE, counter=0, dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0 and captured data=0 immediately, independent of clk.
REQ-035 Reset during ACCESS SHALL abandon the transaction, and a later dm_ack SHALL be ignored.
REQ-036 After reset, StallM, MisalignM and BusErrM SHALL be 0 until a new access.

Structure
REQ-037 Shared package mem_pkg SHALL hold the size encodings, the FSM state enum and the TIMEOUT_CYCLES default.
REQ-038 A combinational sub-module mem_lane_align SHALL perform store lane placement, be generation and load extraction/extension.

Verification
REQ-039 lw addr 0x100, dm_rdata 0xDEADBEEF, ack on 1st ACCESS cycle -> dm_be=1111, StallM high for 2 cycles, ReadDataM=0xDEADBEEF in DONE.
REQ-040 lb addr 0x103 signed, rdata 0x80112233 -> ReadDataM=0xFFFFFF80; lbu at the same address -> 0x00000080.
REQ-041 sh addr 0x202 data 0x0000ABCD, ack after 5 cycles -> dm_addr=0x200, be=1100, wdata=0xABCDABCD, dm_req high for exactly 5 cycles.
REQ-042 lw addr 0x101 -> MisalignM=1, no dm_req, StallM=0.
REQ-043 lw with no ack, TIMEOUT_CYCLES=4 -> dm_req drops after 4 cycles, BusErrM=1 for one cycle, ReadDataM=0.
REQ-044 rst_n low in ACCESS then ack arrives -> dm_req=0 immediately, ack ignored, state IDLE.
